// File: rtl/cache_pkg.sv
// Shared constants for the cache refill controller: FSM state encoding,
// line geometry and the select encodings driven onto the datapath muxes.
package cache_pkg;

  localparam int LINE_WORDS = 4;
  localparam int WORD_OFF_W = 2;

  // Data-source mux select
  localparam logic SRC_CACHE = 1'b0;
  localparam logic SRC_MEM   = 1'b1;

  // Tag-address mux select
  localparam logic TAG_CPU    = 1'b0;
  localparam logic TAG_VICTIM = 1'b1;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WB     = 2'd1;
  localparam logic [1:0] ST_RF     = 2'd2;
  localparam logic [1:0] ST_RESUME = 2'd3;

  // Index of the last beat of a line burst
  localparam logic [WORD_OFF_W-1:0] LAST_BEAT = WORD_OFF_W'(LINE_WORDS - 1);

endpackage

// File: rtl/cache_perf_cnt.sv
// Two saturating event counters (hits and misses) for the refill controller.
// Only instantiated when CACHE_CTRL_PERF_EN is defined.
module cache_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hit_inc,
  input  logic         miss_inc,
  output logic [W-1:0] hit_cnt,
  output logic [W-1:0] miss_cnt
);

  logic [W-1:0] hit_cnt_q, hit_cnt_d;
  logic [W-1:0] miss_cnt_q, miss_cnt_d;

  // Next-count: increment on event, hold at all-ones once saturated
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_inc && (hit_cnt_q != '1)) begin
      hit_cnt_d = hit_cnt_q + W'(1);
    end
    if (miss_inc && (miss_cnt_q != '1)) begin
      miss_cnt_d = miss_cnt_q + W'(1);
    end
  end

  // Counter registers, cleared by asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss/refill sequencer for a direct-mapped cache with 4-word lines.
// Serves hits in the request cycle; on a miss writes back a dirty victim
// (4 beats), refills the line (4 beats), spends one RESUME cycle and then
// replays the CPU access, which hits.
// Optional build macro: CACHE_CTRL_PERF_EN adds saturating hit/miss counters.
//
// Handshakes: cpu_req is held high until cpu_ready (Mealy, same cycle);
// a memory beat transfers in any cycle where mem_req and mem_ready are both
// high; mem_ready is ignored while mem_req is low. state_dbg exposes the FSM.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 28,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ready,
  input  logic              hit,
  input  logic              dirty,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [1:0]        mem_beat,
  output logic [1:0]        word_sel,
  output logic              data_src_sel,
  output logic              tag_addr_sel,
  output logic              line_we,
  output logic              tag_we,
  output logic              dirty_set,
  output logic [1:0]        state_dbg
`ifdef CACHE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] hit_cnt,
  output logic [PERF_W-1:0] miss_cnt
`endif
);

  logic [1:0]            state_q, state_d;
  logic [WORD_OFF_W-1:0] beat_q, beat_d;

  // Only the word-offset bits of the address matter here; the tag width is
  // a datapath property carried for the parent's benefit.
  logic unused_cfg;
  assign unused_cfg = ^{cpu_addr[ADDR_W-1:4], cpu_addr[1:0], TAG_W[0], PERF_W[0]};

  // FSM next-state, beat counter and Mealy datapath controls
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    cpu_ready    = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_beat     = '0;
    word_sel     = '0;
    data_src_sel = SRC_CACHE;
    tag_addr_sel = TAG_CPU;
    line_we      = 1'b0;
    tag_we       = 1'b0;
    dirty_set    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          if (hit) begin
            cpu_ready    = 1'b1;
            word_sel     = cpu_addr[3:2];
            data_src_sel = SRC_CACHE;
            line_we      = cpu_we;
            dirty_set    = cpu_we;
          end else begin
            beat_d  = '0;
            state_d = dirty ? ST_WB : ST_RF;
          end
        end
      end
      ST_WB: begin
        mem_req      = 1'b1;
        mem_we       = 1'b1;
        tag_addr_sel = TAG_VICTIM;
        data_src_sel = SRC_CACHE;
        word_sel     = beat_q;
        mem_beat     = beat_q;
        if (mem_ready) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == LAST_BEAT) begin
            state_d = ST_RF;
          end
        end
      end
      ST_RF: begin
        mem_req      = 1'b1;
        mem_we       = 1'b0;
        tag_addr_sel = TAG_CPU;
        data_src_sel = SRC_MEM;
        word_sel     = beat_q;
        mem_beat     = beat_q;
        line_we      = mem_ready;
        if (mem_ready) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == LAST_BEAT) begin
            tag_we  = 1'b1;
            state_d = ST_RESUME;
          end
        end
      end
      ST_RESUME: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and beat registers; async reset drops every strobe immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  assign state_dbg = state_q;

`ifdef CACHE_CTRL_PERF_EN
  logic hit_evt, miss_evt;
  assign hit_evt  = (state_q == ST_IDLE) && cpu_req && hit;
  assign miss_evt = (state_q == ST_IDLE) && cpu_req && !hit;

  cache_perf_cnt #(.W(PERF_W)) u_perf (
    .clk      (clk),
    .rst_n    (rst_n),
    .hit_inc  (hit_evt),
    .miss_inc (miss_evt),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: a driver issues CPU accesses and
// pushes the expected memory beats and completion into queues; a monitor pops
// and compares whenever the DUT presents a beat or cpu_ready.
module tb_cache_refill_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic        cpu_ready;
  logic        hit;
  logic        dirty;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ready;
  logic [1:0]  mem_beat;
  logic [1:0]  word_sel;
  logic        data_src_sel;
  logic        tag_addr_sel;
  logic        line_we;
  logic        tag_we;
  logic        dirty_set;
  logic [1:0]  state_dbg;
`ifdef CACHE_CTRL_PERF_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  cache_refill_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_ready    (cpu_ready),
    .hit          (hit),
    .dirty        (dirty),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_ready    (mem_ready),
    .mem_beat     (mem_beat),
    .word_sel     (word_sel),
    .data_src_sel (data_src_sel),
    .tag_addr_sel (tag_addr_sel),
    .line_we      (line_we),
    .tag_we       (tag_we),
    .dirty_set    (dirty_set),
    .state_dbg    (state_dbg)
`ifdef CACHE_CTRL_PERF_EN
    ,
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  // beat entry: {cpu_ready, mem_we, tag_addr_sel, data_src_sel, word_sel, mem_beat, line_we, tag_we}
  logic [9:0] exp_q[$];
  // completion entry: {word_sel, data_src_sel, line_we, dirty_set, mem_we, tag_we, tag_addr_sel}
  logic [8:0] cpu_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int hits_m  = 0;
  int misses_m = 0;
  int mode = 0;  // 0 zero-wait, 1 every 2nd cycle, 2 random
  logic alt = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference expectation for one access, from the protocol rules
  task automatic push_expect(input logic [31:0] a, input logic w, input logic h, input logic d);
    if (!h) begin
      if (d) begin
        for (int b = 0; b < 4; b++)
          exp_q.push_back({1'b0, 1'b1, 1'b1, 1'b0, 2'(b), 2'(b), 1'b0, 1'b0});
      end
      for (int b = 0; b < 4; b++)
        exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b1, 2'(b), 2'(b), 1'b1, (b == 3)});
      misses_m++;
    end
    cpu_q.push_back({a[3:2], 1'b0, w, w, 1'b0, 1'b0, 1'b0});
    hits_m++;
  endtask

  // ---------------- memory responder ----------------
  initial begin
    mem_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (mode)
        0: mem_ready = 1'b1;
        1: begin alt = ~alt; mem_ready = alt; end
        default: mem_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [9:0] act_b;
    logic [9:0] e_b;
    logic [8:0] e_c;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1) begin
        if (mem_req) begin
          act_b = {cpu_ready, mem_we, tag_addr_sel, data_src_sel, word_sel, mem_beat, line_we, tag_we};
          if (exp_q.size() == 0) begin
            check("mem_req_unexpected", {31'd0, mem_req}, 32'd0);
          end else if (mem_ready) begin
            e_b = exp_q.pop_front();
            check("mem_beat_accept", {22'd0, act_b}, {22'd0, e_b});
          end else begin
            check("mem_beat_stall", {22'd0, act_b}, {22'd0, exp_q[0][9:2], 2'b00});
          end
        end else if (cpu_ready) begin
          if (cpu_q.size() == 0) begin
            check("cpu_ready_unexpected", {31'd0, cpu_ready}, 32'd0);
          end else begin
            e_c = cpu_q.pop_front();
            check("cpu_done", {23'd0, word_sel, data_src_sel, line_we, dirty_set, mem_we, tag_we, tag_addr_sel},
                  {23'd0, e_c});
          end
        end else begin
          check("quiet_strobes", {28'd0, line_we, tag_we, dirty_set, mem_we}, 32'd0);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic access(input logic [31:0] a, input logic w, input logic h, input logic d, input int lat_exp);
    int  cyc;
    bit  done;
    bit  pend;
    push_expect(a, w, h, d);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = w; cpu_addr = a; hit = h; dirty = d;
    cyc = 0; done = 0; pend = 0;
    while (!done && cyc < 300) begin
      #3;
      if (cpu_ready) begin
        done = 1;
      end else begin
        if (tag_we) pend = 1;
        @(negedge clk);
        cyc++;
        if (pend) hit = 1'b1;  // refilled line now matches
      end
    end
    if (!done) check("access_timeout", 32'(cyc), 32'd0);
    else if (lat_exp >= 0) check("access_latency", 32'(cyc), 32'(lat_exp));
    @(negedge clk);
    cpu_req = 1'b0;
    hit = 1'($urandom_range(0, 1));
    cpu_addr = $urandom;
  endtask

  task automatic idle_gap(input int n);
    repeat (n) begin
      @(negedge clk);
      hit = 1'($urandom_range(0, 1));
      dirty = 1'($urandom_range(0, 1));
      cpu_addr = $urandom;
    end
  endtask

  // Clean zero-wait miss, reset asserted during refill beat 2
  task automatic reset_mid_refill();
    int guard;
    exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0});
    exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd1, 1'b1, 1'b0});
    exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 1'b1, 1'b0});
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0040; hit = 1'b0; dirty = 1'b0;
    guard = 0;
    #3;
    while (!(mem_req && !mem_we && mem_beat == 2'd2) && guard < 50) begin
      @(negedge clk);
      #3;
      guard++;
    end
    check("reset_reach_beat2", 32'(guard), 32'd3);
    rst_n = 1'b0;
    #1;
    check("reset_mem_req", {31'd0, mem_req}, 32'd0);
    check("reset_strobes", {29'd0, line_we, tag_we, dirty_set}, 32'd0);
    check("reset_state", {30'd0, state_dbg}, 32'd0);
    exp_q.delete();
    cpu_q.delete();
    hits_m = 0;
    misses_m = 0;
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`ifdef CACHE_CTRL_PERF_EN
    check("reset_hit_cnt", hit_cnt, 32'd0);
    check("reset_miss_cnt", miss_cnt, 32'd0);
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a;
    logic w, h, d;
    int m;
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; hit = 1'b0; dirty = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {20'd0, cpu_ready, mem_req, mem_we, mem_beat, word_sel, data_src_sel,
                          tag_addr_sel, line_we, tag_we, dirty_set}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    rst_n = 1'b1;
    idle_gap(2);

    mode = 0;
    access(32'h0000_0008, 1'b0, 1'b1, 1'b0, 0);   // load hit, word 2
    access(32'h0000_000C, 1'b1, 1'b1, 1'b1, 0);   // store hit, word 3
    access(32'h0000_0104, 1'b0, 1'b0, 1'b0, 6);   // clean miss, zero-wait
    access(32'h0000_0208, 1'b0, 1'b0, 1'b1, 10);  // dirty miss, zero-wait
    mode = 1;
    access(32'h0000_0304, 1'b1, 1'b0, 1'b1, -1);  // dirty miss, ready every 2nd cycle
    mode = 0;
    idle_gap(2);

    reset_mid_refill();
    access(32'h0000_0040, 1'b0, 1'b0, 1'b0, 6);   // same line misses again

`ifdef CACHE_CTRL_PERF_EN
    reset_mid_refill();
    access(32'h0000_0010, 1'b0, 1'b1, 1'b0, 0);
    access(32'h0000_0024, 1'b1, 1'b1, 1'b0, 0);
    access(32'h0000_0038, 1'b0, 1'b1, 1'b0, 0);
    access(32'h0000_0400, 1'b0, 1'b0, 1'b0, 6);
    access(32'h0000_0504, 1'b1, 1'b0, 1'b1, 10);
    check("perf_hit_cnt_5", hit_cnt, 32'd5);
    check("perf_miss_cnt_2", miss_cnt, 32'd2);
`endif

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      w = 1'($urandom_range(0, 1));
      h = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      m = $urandom_range(0, 2);
      mode = m;
      access(a, w, h, d, (m != 0) ? -1 : (h ? 0 : (d ? 10 : 6)));
      idle_gap($urandom_range(0, 2));
    end

    mode = 0;
    idle_gap(3);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
`ifdef CACHE_CTRL_PERF_EN
    check("perf_hit_model", hit_cnt, 32'(hits_m));
    check("perf_miss_model", miss_cnt, 32'(misses_m));
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
